// File: rtl/line_buf_window_if.sv
// Pixel-stream bundle for line_buf_window: raw pixel stream in, aligned
// window column plus sync and status out.
interface line_buf_window_if #(
  parameter int COLORDEPTH = 8,
  parameter int M_DEPTH    = 3
);
  logic [COLORDEPTH-1:0]              px_i;
  logic                               dv_i;
  logic                               hs_i;
  logic                               vs_i;
  logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_o;
  logic                               dv_o;
  logic                               hs_o;
  logic                               vs_o;
  logic                               line_end_o;
  logic                               overflow_o;

  modport master (
    output px_i, dv_i, hs_i, vs_i,
    input  vect_o, dv_o, hs_o, vs_o, line_end_o, overflow_o
  );

  modport slave (
    input  px_i, dv_i, hs_i, vs_i,
    output vect_o, dv_o, hs_o, vs_o, line_end_o, overflow_o
  );
endinterface

// File: rtl/line_buf_window.sv
// Line buffer producing an M_DEPTH-tall pixel column per valid pixel, 2-cycle latency.
// Optional macro BORDER_ZERO_EN zeroes rows not yet filled in the current frame.
module line_buf_window #(
  parameter int COLORDEPTH = 8,
  parameter int M_DEPTH    = 3,
  parameter int MAX_WIDTH  = 1024
) (
  input logic           clk,
  input logic           rst,
  line_buf_window_if.slave bus
);
  localparam int CW = $clog2(MAX_WIDTH);
  localparam int WW = (M_DEPTH - 1) * COLORDEPTH;
  localparam logic [CW:0] COL_MAX = (CW + 1)'(MAX_WIDTH);
  localparam logic [CW:0] COL_ONE = (CW + 1)'(1);

  // Column counter has one spare bit so it can sit at MAX_WIDTH once a line overflows.
  logic [CW:0]           col_r;
  logic [CW:0]           col_nxt_s;
  logic [CW:0]           col_pix_s;
  logic                  ovf_pix_s;
  logic                  vs_rise_s;
  logic                  dv_fall_s;
  logic                  rd_en_s;
  logic                  wr_en_s;

  logic [WW-1:0]         mem_r [MAX_WIDTH];
  logic [WW-1:0]         rd_word_r;
  logic [WW-1:0]         wr_word_s;

  logic [COLORDEPTH-1:0] px1_r;
  logic [CW-1:0]         addr1_r;
  logic                  ovf1_r;
  logic                  dv1_r;
  logic                  hs1_r;
  logic                  vs1_r;

  logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_s;
  logic                  overflow_nxt_s;

`ifdef BORDER_ZERO_EN
  localparam int LW = $clog2(M_DEPTH);
  localparam logic [LW-1:0] LF_MAX = LW'(M_DEPTH - 1);
  localparam logic [LW-1:0] LF_ONE = LW'(1);

  logic [LW-1:0] lf_r;
  logic [LW-1:0] lf_nxt_s;
  logic [LW-1:0] lf_pix_s;
  logic [LW-1:0] lf1_r;

  // Lines-filled count for the current frame, saturating at M_DEPTH-1.
  always_comb begin
    lf_pix_s = lf_r;
    lf_nxt_s = lf_r;
    if (vs_rise_s) begin
      lf_pix_s = '0;
      lf_nxt_s = '0;
    end else if (dv_fall_s && (lf_r != LF_MAX)) begin
      lf_nxt_s = lf_r + LF_ONE;
    end else begin
      lf_nxt_s = lf_r;
    end
  end

  // Lines-filled register and its stage-1 copy travelling with the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      lf_r  <= '0;
      lf1_r <= '0;
    end else begin
      lf_r <= lf_nxt_s;
      if (bus.dv_i) begin
        lf1_r <= lf_pix_s;
      end
    end
  end
`endif

  // Edge detection and column tracking; a frame-start pixel is forced to column 0.
  always_comb begin
    vs_rise_s = bus.vs_i & ~vs1_r;
    dv_fall_s = dv1_r & ~bus.dv_i;
    if (vs_rise_s) begin
      col_pix_s = '0;
    end else begin
      col_pix_s = col_r;
    end
    ovf_pix_s = (col_pix_s >= COL_MAX);
    rd_en_s   = bus.dv_i & ~ovf_pix_s;
    if (bus.dv_i) begin
      if (ovf_pix_s) begin
        col_nxt_s = col_pix_s;
      end else begin
        col_nxt_s = col_pix_s + COL_ONE;
      end
    end else if (dv_fall_s || vs_rise_s) begin
      col_nxt_s = '0;
    end else begin
      col_nxt_s = col_r;
    end
  end

  // Column counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
    end else begin
      col_r <= col_nxt_s;
    end
  end

  // Stage 1: capture pixel, address and sync bits alongside the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      px1_r   <= '0;
      addr1_r <= '0;
      ovf1_r  <= 1'b0;
      dv1_r   <= 1'b0;
      hs1_r   <= 1'b0;
      vs1_r   <= 1'b0;
    end else begin
      dv1_r <= bus.dv_i;
      hs1_r <= bus.hs_i;
      vs1_r <= bus.vs_i;
      if (bus.dv_i) begin
        px1_r   <= bus.px_i;
        addr1_r <= col_pix_s[CW-1:0];
        ovf1_r  <= ovf_pix_s;
      end
    end
  end

  // Line RAM read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      rd_word_r <= mem_r[col_pix_s[CW-1:0]];
    end
  end

  // Line RAM write port, one column behind the read so the two never collide.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[addr1_r] <= wr_word_s;
    end
  end

  // Stage 2: age the stored lines by one, assemble the output column.
  always_comb begin
    wr_en_s = dv1_r & ~ovf1_r & ~rst;
    wr_word_s = '0;
    wr_word_s[0 +: COLORDEPTH] = px1_r;
    for (int k = 1; k < M_DEPTH - 1; k++) begin
      wr_word_s[k*COLORDEPTH +: COLORDEPTH] = rd_word_r[(k-1)*COLORDEPTH +: COLORDEPTH];
    end

    vect_s = '0;
    if (dv1_r) begin
      vect_s[0] = px1_r;
      for (int k = 1; k < M_DEPTH; k++) begin
        if (ovf1_r) begin
          vect_s[k] = '0;
`ifdef BORDER_ZERO_EN
        end else if (LW'(k) > lf1_r) begin
          vect_s[k] = '0;
`endif
        end else begin
          vect_s[k] = rd_word_r[(k-1)*COLORDEPTH +: COLORDEPTH];
        end
      end
    end else begin
      vect_s = '0;
    end

    // Overflow is sticky until a frame start reaches the output side.
    if (dv1_r && ovf1_r) begin
      overflow_nxt_s = 1'b1;
    end else if (vs1_r && !bus.vs_o) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = bus.overflow_o;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vect_o     <= '0;
      bus.dv_o       <= 1'b0;
      bus.hs_o       <= 1'b0;
      bus.vs_o       <= 1'b0;
      bus.line_end_o <= 1'b0;
      bus.overflow_o <= 1'b0;
    end else begin
      bus.vect_o     <= vect_s;
      bus.dv_o       <= dv1_r;
      bus.hs_o       <= hs1_r;
      bus.vs_o       <= vs1_r;
      bus.line_end_o <= bus.dv_o & ~dv1_r;
      bus.overflow_o <= overflow_nxt_s;
    end
  end
endmodule

// File: tb/tb_line_buf_window.sv
// Table-driven bench for line_buf_window (MAX_WIDTH=8); expectations follow BORDER_ZERO_EN.
module tb_line_buf_window;
  localparam int CD = 8;
  localparam int MD = 3;
  localparam int MW = 8;
`ifdef BORDER_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buf_window_if #(.COLORDEPTH(CD), .M_DEPTH(MD)) bus ();
  line_buf_window #(.COLORDEPTH(CD), .M_DEPTH(MD), .MAX_WIDTH(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    logic       hs;
    logic       vs;
    logic [7:0] px;
    logic [2:0] chk;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ovf;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic cur_ovf = 1'b0;
  logic prev_edv = 1'b0;

  task automatic add(input logic r, input logic dv, input logic hs, input logic vs,
                     input logic [7:0] px, input logic [2:0] chk,
                     input logic [7:0] e2, input logic [7:0] e1, input logic [7:0] e0);
    vec_t v;
    v.rst = r; v.dv = dv; v.hs = hs; v.vs = vs; v.px = px; v.chk = chk;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.ovf = cur_ovf;
    vq.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic vs_pulse();
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pix(input logic [7:0] px, input logic [2:0] chk,
                     input logic [7:0] e2, input logic [7:0] e1);
    add(1'b0, 1'b1, 1'b0, 1'b0, px, chk, e2, e1, px);
  endtask

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  task automatic check_row(input int j, input logic killed);
    logic       edv, ehs, evs, ele, eovf;
    logic [7:0] ev [3];
    edv  = killed ? 1'b0 : vq[j].dv;
    ehs  = killed ? 1'b0 : vq[j].hs;
    evs  = killed ? 1'b0 : vq[j].vs;
    eovf = killed ? 1'b0 : vq[j].ovf;
    ele  = killed ? 1'b0 : (prev_edv & ~edv);
    check("dv_o", j, 32'(bus.dv_o), 32'(edv));
    check("hs_o", j, 32'(bus.hs_o), 32'(ehs));
    check("vs_o", j, 32'(bus.vs_o), 32'(evs));
    check("line_end_o", j, 32'(bus.line_end_o), 32'(ele));
    check("overflow_o", j, 32'(bus.overflow_o), 32'(eovf));
    if (!edv) begin
      check("vect_o_idle", j, 32'(bus.vect_o), 32'h0);
    end else begin
      ev[0] = vq[j].e0; ev[1] = vq[j].e1; ev[2] = vq[j].e2;
      for (int k = 0; k < MD; k++)
        if (vq[j].chk[k]) check($sformatf("vect_o[%0d]", k), j, 32'(bus.vect_o[k]), 32'(ev[k]));
    end
    prev_edv = edv;
  endtask

  initial begin
    logic [7:0] p;
    logic       rdv;
    rst = 1'b1;
    bus.px_i = 8'h00; bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0;

    // Reset, then a prior frame of 0xFF pixels filling all 8 columns.
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
    idle(2);
    vs_pulse(); idle(1);
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 8; c++) pix(8'hFF, 3'b001, 8'h00, 8'h00);
      idle(2);
    end

    // Basic window: 3 lines x 4 pixels of 16*line+col.
    vs_pulse(); idle(1);
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 4; c++) begin
        p = 8'(16 * l + c);
        if (l == 0)      pix(p, 3'b111, BZ ? 8'h00 : 8'hFF, BZ ? 8'h00 : 8'hFF);
        else if (l == 1) pix(p, 3'b111, BZ ? 8'h00 : 8'hFF, 8'(c));
        else             pix(p, 3'b111, 8'(c), 8'(16 + c));
      end
      idle(2);
    end

    // Overflow: 10-pixel line against MAX_WIDTH=8.
    vs_pulse(); idle(1);
    for (int c = 0; c < 10; c++) begin
      p = 8'(8'h30 + c);
      if (c >= 8) begin
        cur_ovf = 1'b1;
        pix(p, 3'b111, 8'h00, 8'h00);
      end else if (BZ)   pix(p, 3'b111, 8'h00, 8'h00);
      else if (c < 4)    pix(p, 3'b111, 8'(8'h10 + c), 8'(8'h20 + c));
      else               pix(p, 3'b111, 8'hFF, 8'hFF);
    end
    idle(2);
    cur_ovf = 1'b0;
    vs_pulse(); idle(1);

    // Reset mid-line at column 2 of line 1.
    for (int c = 0; c < 4; c++)
      pix(8'(8'h40 + c), 3'b111, BZ ? 8'h00 : 8'(8'h20 + c), BZ ? 8'h00 : 8'(8'h30 + c));
    idle(2);
    pix(8'h50, 3'b111, BZ ? 8'h00 : 8'h30, 8'h40);
    pix(8'h51, 3'b111, 8'h00, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h52, 3'b000, 8'h00, 8'h00, 8'h00);
    pix(8'h53, 3'b111, BZ ? 8'h00 : 8'h40, BZ ? 8'h00 : 8'h50);
    pix(8'h54, BZ ? 3'b111 : 3'b001, 8'h00, 8'h00);
    idle(2);

    // Sync alignment under pseudo-random dv/hs/vs; lines kept at most 5 pixels.
    vs_pulse(); idle(1);
    for (int i = 0; i < 60; i++) begin
      rdv = (i % 6 == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      add(1'b0, rdv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 3'b000, 8'h00, 8'h00, 8'h00);
    end
    idle(4);

    for (int i = 0; i < vq.size(); i++) begin
      rst      = vq[i].rst;
      bus.dv_i = vq[i].dv;
      bus.hs_i = vq[i].hs;
      bus.vs_i = vq[i].vs;
      bus.px_i = vq[i].px;
      @(posedge clk);
      #1;
      if (i >= 1) check_row(i - 1, vq[i-1].rst | vq[i].rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
